// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl
// Owns an NREGS x DW register bank with per-bit write enables. Two write
// requesters (A: ALU writeback, B: load writeback) share the single write
// port through a round-robin arbiter. Byte masks are expanded into per-bit
// enables. A sequential clear sweep zeroes the bank one register per cycle.
// Two read ports decode storage combinationally, with no write bypass.
module regfile_write_ctrl #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wa_valid,
  output logic          wa_ready,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  input  logic [1:0]    wa_bmask,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [1:0]    wb_bmask,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          clr_req,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] sweep_cnt;
  // Round-robin pointer: 0 favours port A on contention, 1 favours port B.
  logic          prio_b;

  logic [DW-1:0] regs   [NREGS];
  logic [DW-1:0] bit_en [NREGS];

  logic          grant_a;
  logic          grant_b;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_bmask;
  logic [DW-1:0] wr_mask;

  // Arbitrate the two requesters; nothing is granted in reset or while sweeping.
  // NOTE: every signal driven from always_comb gets a default at the top so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && state == IDLE) begin
      if (wa_valid && (!wb_valid || !prio_b)) begin
        grant_a = 1'b1;
      end else if (wb_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign wa_ready = grant_a;
  assign wb_ready = grant_b;
  assign busy     = (state == CLEAR);

  // Select the granted requester and expand its byte mask to per-bit enables.
  always_comb begin
    wr_addr  = '0;
    wr_data  = '0;
    wr_bmask = 2'b00;
    if (grant_a) begin
      wr_addr  = wa_addr;
      wr_data  = wa_data;
      wr_bmask = wa_bmask;
    end else if (grant_b) begin
      wr_addr  = wb_addr;
      wr_data  = wb_data;
      wr_bmask = wb_bmask;
    end
    wr_mask = {{(DW/2){wr_bmask[1]}}, {(DW/2){wr_bmask[0]}}};
  end

  // Per-register bit enables: reset and the sweep force full-width enables
  // with zero data; otherwise only the granted destination sees the mask.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      bit_en[i] = '0;
      if (reset) begin
        bit_en[i] = '1;
      end else if (state == CLEAR && sweep_cnt == AW'(i)) begin
        bit_en[i] = '1;
      end else if ((grant_a || grant_b) && wr_addr == AW'(i)) begin
        bit_en[i] = wr_mask;
      end
    end
  end

  // Storage update: each bit loads wr_data where enabled, otherwise holds.
  // NOTE: the bank has no reset branch of its own; reset reaches it through
  // the enable path (all enables high, data zero), so the storage stays a
  // plain enable-register array rather than a reset-per-flop structure.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      regs[i] <= (regs[i] & ~bit_en[i]) | (wr_data & bit_en[i]);
    end
  end

  // Control FSM: idle/clear sequencing, sweep counter and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sweep_cnt <= '0;
      prio_b    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
          end
        end
        CLEAR: begin
          if (sweep_cnt == AW'(NREGS - 1)) begin
            sweep_cnt <= '0;
            state     <= IDLE;
          end else begin
            sweep_cnt <= sweep_cnt + AW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          sweep_cnt <= '0;
        end
      endcase
      if (grant_a) begin
        prio_b <= 1'b1;
      end else if (grant_b) begin
        prio_b <= 1'b0;
      end
    end
  end

  // Read ports: straight decode of storage, no bypass of the write in flight.
  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Controller that owns an 8-entry x 16-bit register bank built from per-bit-enable register storage.
- Arbitrates two independent write requesters onto the bank's single write port:
  - Port A: ALU writeback.
  - Port B: load/memory writeback.
- Expands 2-bit byte masks into 16-bit per-bit enable vectors and serves two combinational read ports.
- Runs a sequential clear sweep on request. Sits between the execute/writeback stages and the operand fetch logic.

Parameters:
- NREGS, 8, number of registers in the bank (power of two).
- AW, 3, register address width (log2 NREGS).
- DW, 16, register data width (must be 16; one byte-mask bit per 8 bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wa_valid  input  1  port A write request.
- wa_ready  output  1  port A write granted this cycle.
- wa_addr  input  AW  port A destination register.
- wa_data  input  DW  port A write data.
- wa_bmask  input  2  port A byte mask; bit0 selects [7:0], bit1 selects [15:8].
- wb_valid  input  1  port B write request.
- wb_ready  output  1  port B write granted this cycle.
- wb_addr  input  AW  port B destination register.
- wb_data  input  DW  port B write data.
- wb_bmask  input  2  port B byte mask.
- ra_addr  input  AW  read port A address.
- ra_data  output  DW  read port A data (combinational from storage).
- rb_addr  input  AW  read port B address.
- rb_data  output  DW  read port B data (combinational from storage).
- clr_req  input  1  request sequential clear of all registers.
- busy  output  1  high while clear sweep is in progress.

Behaviour:
- Reset (synchronous, active-high, clock clk): all NREGS registers forced to 0 in the same edge (all bit enables asserted together with reset). FSM to IDLE, sweep counter to 0, priority pointer to A. After reset: busy=0, wa_ready=0, wb_ready=0, ra_data/rb_data=0.
- FSM states: IDLE, CLEAR.
- IDLE:
  - At most one write accepted per cycle.
  - Only A valid: wa_ready=1.
  - Only B valid: wb_ready=1.
  - Both valid: grant goes to the port indicated by the priority pointer.
  - Pointer update: after any grant, the pointer moves to the non-granted port (round-robin), so under continuous contention grants alternate A,B,A,B.
  - ready is never asserted without the matching valid. Both ready are never high in the same cycle.
- Write effect: on the accepting edge, register[addr] bits [7:0] load data[7:0] iff bmask[0]; bits [15:8] load data[15:8] iff bmask[1]. bmask=00 is still accepted (ready=1) and the register is unchanged.
- Read ports: pure combinational decode of storage. No write-to-read bypass; a read of the register being written returns the old value in the write cycle and the new value from the next cycle.
- IDLE -> CLEAR: clr_req=1 sampled in IDLE. A write granted in that same cycle still commits; the sweep clears it later.
- CLEAR:
  - busy=1; wa_ready=wb_ready=0.
  - Each cycle clears register[counter] (full 16-bit enable, data 0), then counter increments.
  - After clearing register NREGS-1, counter wraps to 0 and FSM returns to IDLE. Total: exactly NREGS cycles with busy=1.
  - clr_req during CLEAR is ignored (no restart, no extension).
  - Requesters' valid/data may change freely while busy; nothing is accepted.
  - Reads during CLEAR return live contents: already-swept registers read 0.
- Reset mid-sweep: immediate return to IDLE with all registers 0 and counter 0. Any pending requester valid is not granted in the reset cycle.
- Priority pointer is unchanged by the clear sweep.

Test Plan:
- Reset, then A writes addr3=0xBEEF bmask=11 → wa_ready=1 that cycle; next cycle ra_addr=3 gives ra_data=0xBEEF.
- Reg5=0x1234; B writes addr5 data=0xABCD bmask=10 → reg5=0xAB34. Then bmask=00 write → wb_ready=1, reg5 stays 0xAB34.
- Both valid continuously for 4 cycles (A→r1, B→r2) → grants A,B,A,B. Never both ready in one cycle. After reset the first contended grant goes to A.
- Load r0..r7 with 0x0101*i, pulse clr_req with a concurrent A write to r6=0xFFFF:
  - The write commits; busy=1 for exactly 8 cycles; no ready during busy.
  - Reads show r0..rk=0 progressively; all registers=0 at the end.
  - clr_req held high during the sweep does not extend busy.
- Assert reset at the 3rd cycle of a sweep → next cycle busy=0, all reads 0, and the first subsequent write is accepted normally.
- Read during write: ra_addr=4 while A writes r4=0x5555 (old value 0x0000) → ra_data=0x0000 that cycle, 0x5555 the next.
